refr_sched: RTL

REFR_SCHED -- requirements
Module: refr_sched

---
 rtl/refr_sched.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/refr_sched.sv
// refr_sched -- DRAM refresh scheduler.
//
// This block tracks refresh debt against a periodic interval tick. It pauses
// the traffic source and precharges the target bank(s) where needed. It then
// issues all-bank, per-bank or pair-bank refresh commands through a
// registered request/ack handshake. The block also opportunistically pulls
// refreshes in while traffic is idle.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   en, policy        refresh enable; mode 0 NOREF, 1 REFAB, 2 REFPB, 3 REFP2B
//   trefi_ab/pb       all-bank / per-bank refresh interval in clocks
//   idle_hint         no pending traffic, pull-in allowed
//   pause_req/ack     traffic-source pause handshake
//   ref_req/ack       command handshake; ref_cmd 0 NOP,1 PREAB,2 PREPB,3 REFAB,4 REFPB
//   ref_bk            bank for PREPB/REFPB
//   obs_*             broadcast of issued commands (0 ACT,1 PREPB,2 PREAB)
//   pending, credit   postponed refreshes owed / pulled-in refreshes banked
//   ref_idle, err     scheduler idle / postpone limit exceeded (sticky)
module refr_sched #(
    parameter int unsigned NUM_BK   = 16,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_POST = 8,
    parameter int unsigned MAX_PULL = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [1:0]                        policy,
    input  logic [CNT_W-1:0]                  trefi_ab,
    input  logic [CNT_W-1:0]                  trefi_pb,
    input  logic                              idle_hint,
    output logic                              pause_req,
    input  logic                              paused_ack,
    output logic                              ref_req,
    input  logic                              ref_ack,
    output logic [2:0]                        ref_cmd,
    output logic [$clog2(NUM_BK)-1:0]         ref_bk,
    input  logic                              obs_valid,
    input  logic [1:0]                        obs_cmd,
    input  logic [$clog2(NUM_BK)-1:0]         obs_bk,
    output logic [$clog2(MAX_POST*NUM_BK):0]  pending,
    output logic [$clog2(MAX_POST*NUM_BK):0]  credit,
    output logic                              ref_idle,
    output logic                              err
);
    localparam int unsigned BK_W = $clog2(NUM_BK);
    localparam int unsigned PC_W = $clog2(MAX_POST*NUM_BK) + 1;
    localparam int unsigned HALF = NUM_BK / 2;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PAUSE, S_PRE, S_REF, S_ERROR} state_t;
    typedef enum logic [1:0] {M_NOREF, M_REFAB, M_REFPB, M_REFP2B} mode_t;
    typedef enum logic [2:0] {C_NOP, C_PREAB, C_PREPB, C_REFAB, C_REFPB} cmd_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    cmd_t              cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, ivl;
    logic [PC_W-1:0]   pend_q, pend_d, cred_q, cred_d;
    logic [BK_W-1:0]   bk_ptr_q, bk_ptr_d, bk_hi, rbk_q, rbk_d;
    logic [NUM_BK-1:0] open_q, open_d;
    logic              pull_q, pull_d, hi_q, hi_d, req_q, req_d;
    logic              active, tick, xfer, ref_fin, tgt_open, overflow;
    int unsigned       lim, plim;

    // Per-mode postpone/pull-in limits and tick interval.
    always_comb begin
        lim  = MAX_POST;
        plim = MAX_PULL;
        ivl  = trefi_ab;
        case (mode_q)
            M_REFPB: begin
                lim  = MAX_POST * NUM_BK;
                plim = MAX_PULL * NUM_BK;
                ivl  = trefi_pb;
            end
            M_REFP2B: begin
                lim  = MAX_POST * NUM_BK / 2;
                plim = MAX_PULL * NUM_BK / 2;
                ivl  = trefi_pb << 1;
            end
            default: ;
        endcase
    end

    // In pair mode bk_ptr stays below NUM_BK/2, so this is the partner bank.
    assign bk_hi  = bk_ptr_q + BK_W'(HALF);
    assign active = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign tick   = active && (cnt_q == '0);
    assign cnt_d  = !active ? '0 : (tick ? ivl - 1'b1 : cnt_q - 1'b1);
    assign xfer   = req_q && ref_ack;
    assign ref_fin = (state_q == S_REF) && xfer;

    always_comb begin
        case (mode_q)
            M_REFAB:  tgt_open = |open_q;
            M_REFPB:  tgt_open = open_q[bk_ptr_q];
            M_REFP2B: tgt_open = open_q[bk_ptr_q] | open_q[bk_hi];
            default:  tgt_open = 1'b0;
        endcase
    end

    always_comb begin
        open_d = open_q;
        if (obs_valid) begin
            case (obs_cmd)
                2'd0:    open_d[obs_bk] = 1'b1;
                2'd1:    open_d[obs_bk] = 1'b0;
                2'd2:    open_d = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        cred_d   = cred_q;
        bk_ptr_d = bk_ptr_q;
        pull_d   = pull_q;
        hi_d     = hi_q;
        overflow = 1'b0;

        // A tick that coincides with a normal REF ack is absorbed by it,
        // so pending sitting at the limit is not an overflow in that cycle.
        if (tick) begin
            if (cred_q != '0)
                cred_d = cred_q - 1'b1;
            else if (32'(pend_q) == lim && !(ref_fin && !pull_q))
                overflow = 1'b1;
            else
                pend_d = pend_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                pend_d   = '0;
                cred_d   = '0;
                bk_ptr_d = '0;
                pull_d   = 1'b0;
                hi_d     = 1'b0;
                if (en && policy != M_NOREF) begin
                    state_d = S_ARM;
                    mode_d  = mode_t'(policy);
                end
            end
            S_ARM: begin
                // Decide on post-tick pending so a tick landing here is
                // served as a normal refresh rather than as a pull-in.
                if (pend_d != '0) begin
                    state_d = S_PAUSE;
                    pull_d  = 1'b0;
                end else if (!en || policy != mode_q) begin
                    state_d = S_IDLE;
                    cred_d  = '0;
                end else if (idle_hint && 32'(cred_d) < plim) begin
                    state_d = S_PAUSE;
                    pull_d  = 1'b1;
                end
            end
            S_PAUSE: begin
                if (paused_ack) begin
                    // Pair mode starts on the upper bank if the lower is closed.
                    hi_d    = (mode_q == M_REFP2B) && !open_q[bk_ptr_q];
                    state_d = tgt_open ? S_PRE : S_REF;
                end
            end
            S_PRE: begin
                if (xfer) begin
                    if (mode_q == M_REFP2B && !hi_q && open_q[bk_hi])
                        hi_d = 1'b1;
                    else
                        state_d = S_REF;
                end
            end
            S_REF: begin
                if (xfer) begin
                    if (pull_q)
                        cred_d = cred_d + 1'b1;
                    else
                        pend_d = pend_d - 1'b1;
                    if (mode_q == M_REFPB)
                        bk_ptr_d = bk_ptr_q + 1'b1;
                    else if (mode_q == M_REFP2B)
                        bk_ptr_d = (bk_ptr_q + 1'b1) & BK_W'(HALF - 1);
                    state_d = S_ARM;
                end
            end
            default: ;
        endcase

        if (overflow)
            state_d = S_ERROR;
    end

    // Registered request: command is latched on the rising request and held
    // until the ack; request is dropped for one cycle after every transfer.
    always_comb begin
        req_d = 1'b0;
        cmd_d = C_NOP;
        rbk_d = rbk_q;
        if ((state_d == S_PRE || state_d == S_REF) && !xfer) begin
            req_d = 1'b1;
            if (req_q) begin
                cmd_d = cmd_q;
            end else if (state_d == S_PRE) begin
                cmd_d = (mode_q == M_REFAB) ? C_PREAB : C_PREPB;
                if (mode_q == M_REFAB)
                    rbk_d = '0;
                else if (mode_q == M_REFP2B && hi_d)
                    rbk_d = bk_hi;
                else
                    rbk_d = bk_ptr_q;
            end else begin
                cmd_d = (mode_q == M_REFAB) ? C_REFAB : C_REFPB;
                rbk_d = (mode_q == M_REFAB) ? '0 : bk_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_NOREF;
            cmd_q    <= C_NOP;
            cnt_q    <= '0;
            pend_q   <= '0;
            cred_q   <= '0;
            bk_ptr_q <= '0;
            rbk_q    <= '0;
            open_q   <= '0;
            pull_q   <= 1'b0;
            hi_q     <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            cred_q   <= cred_d;
            bk_ptr_q <= bk_ptr_d;
            rbk_q    <= rbk_d;
            open_q   <= open_d;
            pull_q   <= pull_d;
            hi_q     <= hi_d;
            req_q    <= req_d;
        end
    end

    assign pause_req = (state_q == S_PAUSE) || (state_q == S_PRE) || (state_q == S_REF);
    assign ref_idle  = (state_q == S_IDLE);
    assign err       = (state_q == S_ERROR);
    assign ref_req   = req_q;
    assign ref_cmd   = cmd_q;
    assign ref_bk    = rbk_q;
    assign pending   = pend_q;
    assign credit    = cred_q;

endmodule
